chdr_wrr_pkt_scheduler: RTL and testbench
=========================================

Name: chdr_wrr_pkt_scheduler

Overview:
- Weighted round-robin CHDR packet scheduler that shares one CHDR output stream between NUM_PORTS CHDR input streams.
- Grants are made at packet granularity. A granted port may send up to its configured weight of packets before the grant moves to the next requester.
- Sits in front of the scheduler block's noc_shell data port. Register-mapped weight and enable fields are driven from the block's control-port registers.

Parameters:
- CHDR_W, 64, CHDR bus width in bits.
- NUM_PORTS, 4, number of input requesters (2..16).
- WEIGHT_W, 8, width of each per-port packet weight.
- CNT_W, 16, width of each per-port sent-packet counter.

Ports:
- rfnoc_chdr_clk  in  1  single clock for all logic.
- rfnoc_chdr_rst_n  in  1  reset, asynchronous assert, active-low.
- s_rfnoc_chdr_tdata  in  CHDR_W*NUM_PORTS  input data, port i at [CHDR_W*i +: CHDR_W].
- s_rfnoc_chdr_tlast  in  NUM_PORTS  end of packet per port.
- s_rfnoc_chdr_tvalid  in  NUM_PORTS  valid per port.
- s_rfnoc_chdr_tready  out  NUM_PORTS  ready per port.
- m_rfnoc_chdr_tdata  out  CHDR_W  output data.
- m_rfnoc_chdr_tlast  out  1  output end of packet.
- m_rfnoc_chdr_tvalid  out  1  output valid.
- m_rfnoc_chdr_tready  in  1  output ready.
- cfg_weight  in  WEIGHT_W*NUM_PORTS  packets per grant; 0 is treated as 1.
- cfg_enable  in  NUM_PORTS  port may be granted when 1.
- sts_grant  out  $clog2(NUM_PORTS)  currently or last granted port.
- sts_busy  out  1  high while in PASS or HOLD.
- sts_pkt_cnt  out  CNT_W*NUM_PORTS  packets forwarded per port, wraps.

Behaviour:
- Reset values: m_rfnoc_chdr_tvalid=0, s_rfnoc_chdr_tready=0, sts_grant=0, sts_busy=0, all sts_pkt_cnt=0, credit=0, rr pointer=0, state=ARB.
- Reset asserted mid-packet aborts immediately. The downstream side sees a truncated packet; this is accepted and documented, and no recovery is attempted.
- Datapath is a combinational mux selected by a registered grant:
  - m_tdata, m_tlast and m_tvalid follow port[grant] only in PASS; otherwise m_tvalid=0.
  - s_tready[grant] = m_tready in PASS; all other s_tready bits are 0.
  - There is no buffering, so no words are added or dropped.
- State ARB:
  - Requesters = s_tvalid & cfg_enable.
  - Search from (last_grant+1) mod NUM_PORTS upward, wrapping. The first requester found wins.
  - On a winner: register grant, load credit = max(cfg_weight[grant],1), go to PASS. This costs one bubble cycle per arbitration.
  - With no requester, stay in ARB.
- State PASS:
  - Forward words. On a tlast handshake (m_tvalid & m_tready & m_tlast): increment sts_pkt_cnt[grant] and decrement credit.
  - If credit was 1, go to ARB.
  - Otherwise go to HOLD.
- State HOLD (packet boundary with credit remaining). Conditions are evaluated in priority order:
  - If cfg_enable[grant]=0, go to ARB.
  - Else if s_tvalid[grant]=1, go to PASS with no bubble; the first word is forwarded the cycle after entering PASS.
  - Else if any other enabled port is valid, go to ARB; the pointer advances past grant.
  - Else stay in HOLD.
- cfg_enable and cfg_weight are sampled only in ARB and HOLD, never mid-packet. Clearing the enable of the granted port mid-packet completes the packet, then releases the grant.
- Weight arithmetic: credit is WEIGHT_W bits. 255 gives 255 packets. Credit never underflows.
- Counters wrap modulo 2^CNT_W.
- Simultaneous events: a tlast handshake and an enable change in the same cycle use the enable value at the next HOLD or ARB evaluation.
- Fairness: a single continuously-valid port with all other ports enabled but idle is re-granted back to back; it pays one ARB bubble every weight packets.

Decomposition:
- Package rfnoc_sched_pkg holds:
  - the state enum sched_state_t {ARB, PASS, HOLD};
  - the function clog2_safe;
  - the localparam default weight 1.
- Natural sub-module: rr_priority_select.
  - Inputs: request vector, last grant.
  - Outputs: found, index.
  - Purely combinational, reused by other arbiters.

Test Plan:
- Reset, then ports 0 and 1 each continuously send 4-word packets, weights 1/1, all enabled. Required: output alternates 0,1,0,1; sts_pkt_cnt = 4/4 after 8 packets.
- Weights 3/1, same traffic. Required: port order 0,0,0,1,0,0,0,1; no word lost or reordered within a packet; tlast count equals 8.
- Port 2 only, weight 4, sending 10 packets, with m_tready toggling at 25% stall. Required: all 10 packets forwarded intact; ARB bubble only on packets 1, 5 and 9.
- Clear cfg_enable[0] in the middle of a 64-word port-0 packet while port 1 is valid. Required: all 64 words complete with tlast, then grant moves to port 1; no further port-0 grants.
- Drop rfnoc_chdr_rst_n during word 10 of a packet. Required: m_tvalid=0 and s_tready=0 asynchronously; counters=0; after release, the first grant goes to port 1 (pointer=0 search starts at 1).
- Set cfg_weight=0 on port 3 and preload sts_pkt_cnt[3] to 0xFFFF by sending 65535 packets. Required: 0 behaves as weight 1; the next packet wraps the counter to 0.

Source files
------------

// File: rtl/rfnoc_sched_pkg.sv
// Shared types and helpers for the CHDR packet schedulers.
package rfnoc_sched_pkg;

  // Scheduler states: arbitrate, pass a packet, hold a granted port between packets
  typedef enum logic [1:0] {
    ARB  = 2'd0,
    PASS = 2'd1,
    HOLD = 2'd2
  } sched_state_t;

  // Credit loaded when a port's configured weight is zero
  localparam int unsigned DEFAULT_WEIGHT = 1;

  // Index width that stays at least one bit for degenerate sizes
  function automatic int unsigned clog2_safe(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Round-robin priority search: first requester strictly after last_grant, wrapping.
module rr_priority_select #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     request,
  input  logic [IDX_W-1:0] last_grant,
  output logic             found,
  output logic [IDX_W-1:0] index
);

  // Walk offsets 1..N from the last grant; the first hit wins
  always_comb begin
    int unsigned pos;
    found = 1'b0;
    index = '0;
    pos   = 0;
    for (int unsigned off = 1; off <= N; off++) begin
      pos = (32'(last_grant) + off) % N;
      if (!found && request[IDX_W'(pos)]) begin
        found = 1'b1;
        index = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/chdr_wrr_pkt_scheduler.sv
// Weighted round-robin CHDR packet scheduler: NUM_PORTS inputs share one output,
// granted a packet at a time, up to cfg_weight packets per grant.
module chdr_wrr_pkt_scheduler
  import rfnoc_sched_pkg::*;
#(
  parameter int unsigned CHDR_W    = 64,
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned WEIGHT_W  = 8,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                          rfnoc_chdr_clk,
  input  logic                          rfnoc_chdr_rst_n,
  input  logic [CHDR_W*NUM_PORTS-1:0]   s_rfnoc_chdr_tdata,
  input  logic [NUM_PORTS-1:0]          s_rfnoc_chdr_tlast,
  input  logic [NUM_PORTS-1:0]          s_rfnoc_chdr_tvalid,
  output logic [NUM_PORTS-1:0]          s_rfnoc_chdr_tready,
  output logic [CHDR_W-1:0]             m_rfnoc_chdr_tdata,
  output logic                          m_rfnoc_chdr_tlast,
  output logic                          m_rfnoc_chdr_tvalid,
  input  logic                          m_rfnoc_chdr_tready,
  input  logic [WEIGHT_W*NUM_PORTS-1:0] cfg_weight,
  input  logic [NUM_PORTS-1:0]          cfg_enable,
  output logic [$clog2(NUM_PORTS)-1:0]  sts_grant,
  output logic                          sts_busy,
  output logic [CNT_W*NUM_PORTS-1:0]    sts_pkt_cnt
);

  localparam int unsigned IDX_W = clog2_safe(NUM_PORTS);

  sched_state_t        state;
  logic [IDX_W-1:0]    grant;
  logic [WEIGHT_W-1:0] credit;
  logic                busy;
  logic [CNT_W-1:0]    pkt_cnt [NUM_PORTS];

  logic [NUM_PORTS-1:0] req_c;
  logic                 found_c;
  logic [IDX_W-1:0]     win_c;
  logic [WEIGHT_W-1:0]  win_weight_c;
  logic [WEIGHT_W-1:0]  load_credit_c;
  logic                 eop_c;
  logic                 others_c;

  // Eligible requesters and the competitors of the current grant
  assign req_c    = s_rfnoc_chdr_tvalid & cfg_enable;
  assign others_c = |(req_c & ~(NUM_PORTS'(1) << grant));

  rr_priority_select #(
    .N     (NUM_PORTS),
    .IDX_W (IDX_W)
  ) u_rr_select (
    .request    (req_c),
    .last_grant (grant),
    .found      (found_c),
    .index      (win_c)
  );

  // Credit for a new grant; a zero weight still allows one packet
  assign win_weight_c  = cfg_weight[WEIGHT_W*win_c +: WEIGHT_W];
  assign load_credit_c = (win_weight_c == '0) ? WEIGHT_W'(DEFAULT_WEIGHT) : win_weight_c;

  // Unbuffered datapath: only the granted port is connected, and only in PASS
  always_comb begin
    m_rfnoc_chdr_tvalid = 1'b0;
    m_rfnoc_chdr_tlast  = 1'b0;
    m_rfnoc_chdr_tdata  = '0;
    s_rfnoc_chdr_tready = '0;
    if (state == PASS) begin
      m_rfnoc_chdr_tvalid        = s_rfnoc_chdr_tvalid[grant];
      m_rfnoc_chdr_tlast         = s_rfnoc_chdr_tlast[grant];
      m_rfnoc_chdr_tdata         = s_rfnoc_chdr_tdata[CHDR_W*grant +: CHDR_W];
      s_rfnoc_chdr_tready[grant] = m_rfnoc_chdr_tready;
    end
  end

  assign eop_c = m_rfnoc_chdr_tvalid & m_rfnoc_chdr_tready & m_rfnoc_chdr_tlast;

  // Scheduler FSM, grant/credit bookkeeping and per-port packet counters
  always_ff @(posedge rfnoc_chdr_clk or negedge rfnoc_chdr_rst_n) begin
    if (!rfnoc_chdr_rst_n) begin
      state  <= ARB;
      grant  <= '0;
      credit <= '0;
      busy   <= 1'b0;
      for (int i = 0; i < int'(NUM_PORTS); i++) pkt_cnt[i] <= '0;
    end else begin
      case (state)
        ARB: begin
          if (found_c) begin
            grant  <= win_c;
            credit <= load_credit_c;
            state  <= PASS;
            busy   <= 1'b1;
          end
        end
        PASS: begin
          if (eop_c) begin
            pkt_cnt[grant] <= pkt_cnt[grant] + CNT_W'(1);
            if (credit != '0) credit <= credit - WEIGHT_W'(1);
            if (credit <= WEIGHT_W'(1)) begin
              state <= ARB;
              busy  <= 1'b0;
            end else begin
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (!cfg_enable[grant]) begin
            state <= ARB;
            busy  <= 1'b0;
          end else if (s_rfnoc_chdr_tvalid[grant]) begin
            state <= PASS;
          end else if (others_c) begin
            state <= ARB;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ARB;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Status outputs straight from registers
  always_comb begin
    sts_grant = grant;
    sts_busy  = busy;
    for (int i = 0; i < int'(NUM_PORTS); i++) sts_pkt_cnt[CNT_W*i +: CNT_W] = pkt_cnt[i];
  end

endmodule

// File: tb/tb_chdr_wrr_pkt_scheduler.sv
// Directed bench for chdr_wrr_pkt_scheduler with packet sources and an output monitor.
module tb_chdr_wrr_pkt_scheduler;

  localparam int CHDR_W = 64;
  localparam int NP     = 4;
  localparam int WW     = 8;
  localparam int CW     = 8;

  logic                 clk;
  logic                 rst_n;
  logic [CHDR_W*NP-1:0] s_tdata;
  logic [NP-1:0]        s_tlast;
  logic [NP-1:0]        s_tvalid;
  logic [NP-1:0]        s_tready;
  logic [CHDR_W-1:0]    m_tdata;
  logic                 m_tlast;
  logic                 m_tvalid;
  logic                 m_tready;
  logic [WW*NP-1:0]     cfg_weight;
  logic [NP-1:0]        cfg_enable;
  logic [1:0]           sts_grant;
  logic                 sts_busy;
  logic [CW*NP-1:0]     sts_pkt_cnt;

  chdr_wrr_pkt_scheduler #(
    .CHDR_W    (CHDR_W),
    .NUM_PORTS (NP),
    .WEIGHT_W  (WW),
    .CNT_W     (CW)
  ) dut (
    .rfnoc_chdr_clk      (clk),
    .rfnoc_chdr_rst_n    (rst_n),
    .s_rfnoc_chdr_tdata  (s_tdata),
    .s_rfnoc_chdr_tlast  (s_tlast),
    .s_rfnoc_chdr_tvalid (s_tvalid),
    .s_rfnoc_chdr_tready (s_tready),
    .m_rfnoc_chdr_tdata  (m_tdata),
    .m_rfnoc_chdr_tlast  (m_tlast),
    .m_rfnoc_chdr_tvalid (m_tvalid),
    .m_rfnoc_chdr_tready (m_tready),
    .cfg_weight          (cfg_weight),
    .cfg_enable          (cfg_enable),
    .sts_grant           (sts_grant),
    .sts_busy            (sts_busy),
    .sts_pkt_cnt         (sts_pkt_cnt)
  );

  // Source state per port: packets queued, packet length, word index, sequence number
  int pkts_left [NP] = '{0, 0, 0, 0};
  int plen      [NP] = '{4, 4, 4, 4};
  int widx      [NP] = '{0, 0, 0, 0};
  int pseq      [NP] = '{0, 0, 0, 0};
  logic stall_en = 1'b0;
  int   cyc = 0;

  // Monitor captures: words {tlast,data}, packet source ports, per-packet bubble flag
  logic [64:0] mw [$];
  int          mport [$];
  logic        bub [$];
  logic        idle_seen = 1'b0;
  int          eord [$];

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Packet sources and output ready; data word = {port, seq, word index}
  initial begin
    s_tvalid = '0;
    s_tlast  = '0;
    s_tdata  = '0;
    m_tready = 1'b1;
    forever begin
      @(posedge clk);
      for (int p = 0; p < NP; p++) begin
        if (s_tvalid[p] && s_tready[p]) begin
          if (widx[p] == plen[p] - 1) begin
            widx[p] = 0;
            pseq[p]++;
            pkts_left[p]--;
          end else begin
            widx[p]++;
          end
        end
      end
      cyc++;
      #1;
      m_tready = stall_en ? ((cyc % 4) != 3) : 1'b1;
      for (int p = 0; p < NP; p++) begin
        s_tvalid[p] = (pkts_left[p] > 0);
        s_tlast[p]  = (widx[p] == plen[p] - 1);
        s_tdata[CHDR_W*p +: CHDR_W] = {8'(p), 24'(pseq[p]), 32'(widx[p])};
      end
    end
  end

  // Output monitor
  initial begin
    forever begin
      @(posedge clk);
      if (!sts_busy) idle_seen = 1'b1;
      if (m_tvalid && m_tready) begin
        mw.push_back({m_tlast, m_tdata});
        if (m_tdata[31:0] == 32'd0) begin
          bub.push_back(idle_seen);
          idle_seen = 1'b0;
        end
        if (m_tlast) mport.push_back(int'(m_tdata[63:56]));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no end of run, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CW-1:0] cnt_of(input int p);
    return sts_pkt_cnt[CW*p +: CW];
  endfunction

  function automatic logic [63:0] ports_word();
    logic [63:0] r;
    r = '0;
    foreach (mport[i]) r = {r[59:0], 4'(mport[i])};
    return r;
  endfunction

  function automatic logic [63:0] bubble_word();
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < int'(bub.size()) && i < 64; i++) r[i] = bub[i];
    return r;
  endfunction

  function automatic int bubble_count();
    int c;
    c = 0;
    foreach (bub[i]) if (bub[i]) c++;
    return c;
  endfunction

  // Count words that differ from the packets expected in order eord
  function automatic int integrity_errs();
    int seq [NP];
    int idx;
    int bad;
    int p;
    logic [64:0] e;
    idx = 0;
    bad = 0;
    for (int q = 0; q < NP; q++) seq[q] = 0;
    for (int j = 0; j < int'(eord.size()); j++) begin
      p = eord[j];
      for (int w = 0; w < plen[p]; w++) begin
        e = {(w == plen[p] - 1), 8'(p), 24'(seq[p]), 32'(w)};
        if (idx >= int'(mw.size())) bad++;
        else if (mw[idx] !== e) bad++;
        idx++;
      end
      seq[p]++;
    end
    if (idx != int'(mw.size())) bad++;
    return bad;
  endfunction

  task automatic clear_capture();
    mw.delete();
    mport.delete();
    bub.delete();
    idle_seen = 1'b0;
  endtask

  task automatic clear_sources();
    for (int p = 0; p < NP; p++) begin
      pkts_left[p] = 0;
      widx[p] = 0;
      pseq[p] = 0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_sources();
    repeat (3) @(negedge clk);
    clear_capture();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic set_weights(input int w0, input int w1, input int w2, input int w3);
    cfg_weight = {8'(w3), 8'(w2), 8'(w1), 8'(w0)};
  endtask

  task automatic wait_busy(input string tag);
    int k;
    k = 0;
    while (!sts_busy && k < 50) begin
      @(negedge clk);
      k++;
    end
    check(tag, 64'(sts_busy), 64'd1);
  endtask

  task automatic wait_words(input int n, input string tag);
    int k;
    k = 0;
    while (int'(mw.size()) < n && k < 500) begin
      @(negedge clk);
      k++;
    end
    check(tag, 64'(int'(mw.size()) >= n), 64'd1);
  endtask

  task automatic wait_tlast(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (int'(mport.size()) < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, 64'(int'(mport.size()) >= n), 64'd1);
  endtask

  initial begin
    rst_n      = 1'b0;
    cfg_enable = 4'hF;
    set_weights(1, 1, 1, 1);

    // Reset state
    do_reset();
    check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_s_tready", 64'(s_tready), 64'd0);
    check("rst_grant", 64'(sts_grant), 64'd0);
    check("rst_busy", 64'(sts_busy), 64'd0);
    check("rst_pkt_cnt", 64'(sts_pkt_cnt), 64'd0);

    // Weights 1/1: strict alternation once port 0 holds the first grant
    do_reset();
    set_weights(1, 1, 1, 1);
    cfg_enable = 4'hF;
    plen = '{4, 4, 4, 4};
    pkts_left[0] = 4;
    wait_busy("w11_first_grant");
    pkts_left[1] = 4;
    wait_tlast(8, 400, "w11_done");
    check("w11_order", ports_word(), 64'h0101_0101);
    eord = {0, 1, 0, 1, 0, 1, 0, 1};
    check("w11_integrity", 64'(integrity_errs()), 64'd0);
    check("w11_cnt0", 64'(cnt_of(0)), 64'd4);
    check("w11_cnt1", 64'(cnt_of(1)), 64'd4);

    // Weights 3/1
    do_reset();
    set_weights(3, 1, 1, 1);
    pkts_left[0] = 6;
    wait_busy("w31_first_grant");
    pkts_left[1] = 2;
    wait_tlast(8, 400, "w31_done");
    check("w31_order", ports_word(), 64'h0001_0001);
    eord = {0, 0, 0, 1, 0, 0, 0, 1};
    check("w31_integrity", 64'(integrity_errs()), 64'd0);
    check("w31_tlast_count", 64'(mport.size()), 64'd8);

    // Port 2 alone, weight 4, 10 packets with 25% output stall
    do_reset();
    set_weights(1, 1, 4, 1);
    stall_en = 1'b1;
    plen[2] = 3;
    pkts_left[2] = 10;
    wait_tlast(10, 400, "p2_done");
    stall_en = 1'b0;
    check("p2_order", ports_word(), 64'h22_2222_2222);
    eord = {2, 2, 2, 2, 2, 2, 2, 2, 2, 2};
    check("p2_integrity", 64'(integrity_errs()), 64'd0);
    check("p2_bubbles", bubble_word(), 64'h111);
    check("p2_cnt2", 64'(cnt_of(2)), 64'd10);

    // Clear enable of port 0 mid-packet while port 1 waits
    do_reset();
    set_weights(4, 4, 4, 4);
    plen[0] = 64;
    plen[1] = 4;
    pkts_left[0] = 3;
    wait_busy("en_first_grant");
    pkts_left[1] = 2;
    wait_words(10, "en_mid_packet");
    cfg_enable = 4'b1110;
    wait_tlast(3, 500, "en_done");
    repeat (50) @(negedge clk);
    check("en_order", ports_word(), 64'h011);
    check("en_pkt_total", 64'(mport.size()), 64'd3);
    eord = {0, 1, 1};
    check("en_integrity", 64'(integrity_errs()), 64'd0);
    check("en_cnt0", 64'(cnt_of(0)), 64'd1);
    check("en_cnt1", 64'(cnt_of(1)), 64'd2);
    check("en_grant", 64'(sts_grant), 64'd1);
    check("en_idle_tvalid", 64'(m_tvalid), 64'd0);

    // Reset during word 10 of a packet
    cfg_enable = 4'hF;
    do_reset();
    set_weights(1, 1, 1, 1);
    plen[1] = 4;
    pkts_left[1] = 1;
    wait_tlast(1, 50, "rr_pre_pkt");
    check("rr_pre_cnt1", 64'(cnt_of(1)), 64'd1);
    plen[0] = 16;
    pkts_left[0] = 1;
    mw.delete();
    wait_words(10, "rr_word10");
    check("rr_pre_tvalid", 64'(m_tvalid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rr_async_tvalid", 64'(m_tvalid), 64'd0);
    check("rr_async_tready", 64'(s_tready), 64'd0);
    check("rr_async_busy", 64'(sts_busy), 64'd0);
    check("rr_async_cnt", 64'(sts_pkt_cnt), 64'd0);
    clear_sources();
    repeat (2) @(negedge clk);
    plen[0] = 2;
    plen[1] = 2;
    pkts_left[0] = 1;
    pkts_left[1] = 1;
    clear_capture();
    rst_n = 1'b1;
    wait_tlast(1, 50, "rr_post_first");
    check("rr_post_first_port", 64'(mport.size() > 0 ? mport[0] : -1), 64'd1);
    wait_tlast(2, 50, "rr_post_second");
    check("rr_post_order", ports_word(), 64'h10);

    // Weight 0 on port 3 acts as 1; counter wraps after 2^CW packets
    do_reset();
    set_weights(1, 1, 1, 0);
    plen[3] = 1;
    pkts_left[3] = 255;
    wait_tlast(255, 1500, "w0_fill");
    check("w0_cnt_full", 64'(cnt_of(3)), 64'hFF);
    check("w0_bubbles", 64'(bubble_count()), 64'd255);
    pkts_left[3] = 1;
    wait_tlast(256, 30, "w0_wrap_pkt");
    check("w0_cnt_wrap", 64'(cnt_of(3)), 64'd0);
    check("w0_other_cnts", 64'(sts_pkt_cnt[23:0]), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
